// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: ID/fetch-side control and PC outputs of the PC/branch stage
interface pc_branch_unit_if #(parameter int CNT_W = 16);
  logic             id_stall_i;
  logic             fetch_wait_i;
  logic             beq_i;
  logic             bne_i;
  logic             jump_i;
  logic             jr_i;
  logic [31:0]      rs_data_i;
  logic [31:0]      rt_data_i;
  logic [31:0]      offset_sl2_i;
  logic [31:0]      pc_plus4_id_i;
  logic [25:0]      jump_index_i;
  logic [31:0]      jr_target_i;
  logic [31:0]      pc_o;
  logic [31:0]      pc_plus4_o;
  logic             if_id_flush_o;
  logic             pending_o;
  logic [CNT_W-1:0] redirect_cnt_o;
  modport master (
    output id_stall_i, fetch_wait_i, beq_i, bne_i, jump_i, jr_i, rs_data_i, rt_data_i,
           offset_sl2_i, pc_plus4_id_i, jump_index_i, jr_target_i,
    input  pc_o, pc_plus4_o, if_id_flush_o, pending_o, redirect_cnt_o
  );
  modport slave (
    input  id_stall_i, fetch_wait_i, beq_i, bne_i, jump_i, jr_i, rs_data_i, rt_data_i,
           offset_sl2_i, pc_plus4_id_i, jump_index_i, jr_target_i,
    output pc_o, pc_plus4_o, if_id_flush_o, pending_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, beq/bne/j/jal/jr redirect resolution, IF/ID flush and deferred redirects
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic           clk,
  input logic           rst,
  pc_branch_unit_if.slave bus
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t           state, state_n;
  logic [31:0]      pc, pc_n, pend, pend_n, target;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             eq, redir, flush, accept;
  assign eq     = bus.rs_data_i == bus.rt_data_i;
  assign redir  = bus.jr_i | bus.jump_i | (bus.beq_i & eq) | (bus.bne_i & ~eq);
  assign target = bus.jr_i   ? bus.jr_target_i :
                  bus.jump_i ? {bus.pc_plus4_id_i[31:28], bus.jump_index_i, 2'b00} :
                               bus.pc_plus4_id_i + bus.offset_sl2_i;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    flush   = 1'b0;
    accept  = 1'b0;
    if (state == PENDING) begin
      flush = 1'b1;
      if (!bus.fetch_wait_i) begin
        pc_n    = pend;
        state_n = IDLE;
      end
    end else if (!bus.id_stall_i && redir) begin
      flush  = 1'b1;
      accept = 1'b1;
      if (bus.fetch_wait_i) begin
        pend_n  = target;
        state_n = PENDING;
      end else pc_n = target;
    end else if (!bus.id_stall_i && !bus.fetch_wait_i) pc_n = pc + 32'd4;
  end
  assign cnt_n = (accept && cnt != '1) ? cnt + 1'b1 : cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end
  assign bus.pc_o           = pc;
  assign bus.pc_plus4_o     = pc + 32'd4;
  assign bus.if_id_flush_o  = flush & ~rst;
  assign bus.pending_o      = state == PENDING;
  assign bus.redirect_cnt_o = cnt;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: scoreboard bench, expected PC/state pushed at drive time and popped after the edge
module tb_pc_branch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  pc_branch_unit_if #(.CNT_W(16)) b ();
  pc_branch_unit #(.RESET_PC(RPC), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc = RPC, m_tgt = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_cnt = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clr();
    b.id_stall_i = 0; b.fetch_wait_i = 0; b.beq_i = 0; b.bne_i = 0; b.jump_i = 0; b.jr_i = 0;
    b.rs_data_i = 0; b.rt_data_i = 0; b.offset_sl2_i = 0; b.pc_plus4_id_i = 0;
    b.jump_index_i = 0; b.jr_target_i = 0;
  endtask
  task automatic step(input bit full = 1'b1);
    logic        taken, fl;
    logic [31:0] tg;
    exp_t        e;
    #1;
    taken = b.jr_i || b.jump_i || (b.beq_i && b.rs_data_i == b.rt_data_i) ||
            (b.bne_i && b.rs_data_i != b.rt_data_i);
    if (b.jr_i) tg = b.jr_target_i;
    else if (b.jump_i) tg = {b.pc_plus4_id_i[31:28], b.jump_index_i, 2'b00};
    else tg = b.pc_plus4_id_i + b.offset_sl2_i;
    fl = 1'b0;
    if (rst) begin
      m_pc = RPC; m_pend = 0; m_tgt = 0; m_cnt = 0;
    end else if (m_pend) begin
      fl = 1'b1;
      if (!b.fetch_wait_i) begin m_pc = m_tgt; m_pend = 0; end
    end else if (!b.id_stall_i) begin
      if (taken) begin
        fl = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (b.fetch_wait_i) begin m_tgt = tg; m_pend = 1; end
        else m_pc = tg;
      end else if (!b.fetch_wait_i) m_pc = m_pc + 4;
    end
    if (full) chk("flush", {31'd0, b.if_id_flush_o}, {31'd0, fl});
    q.push_back('{pc: m_pc, pend: m_pend, cnt: m_cnt});
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
    else begin
      e = q.pop_front();
      if (full) begin
        chk("pc", b.pc_o, e.pc);
        chk("pc_plus4", b.pc_plus4_o, e.pc + 32'd4);
        chk("pending", {31'd0, b.pending_o}, {31'd0, e.pend});
        chk("cnt", {16'd0, b.redirect_cnt_o}, {16'd0, e.cnt});
      end
    end
  endtask
  initial begin
    clr();
    @(negedge clk);
    rst = 1; step(); rst = 0;
    chk("t1_reset_pc", b.pc_o, 32'h0);
    repeat (3) step();
    chk("t1_pc_c", b.pc_o, 32'hC);
    b.beq_i = 1; b.rs_data_i = 5; b.rt_data_i = 5;
    b.pc_plus4_id_i = 32'h10; b.offset_sl2_i = 32'hFFFF_FFF0;
    step();
    chk("t2_beq_pc", b.pc_o, 32'h0);
    chk("t2_cnt", {16'd0, b.redirect_cnt_o}, 32'd1);
    b.rt_data_i = 6; step();
    chk("t2_nt_pc", b.pc_o, 32'h4);
    clr(); b.jump_i = 1; b.pc_plus4_id_i = 32'h4000_0008; b.jump_index_i = 26'h0000100;
    step();
    chk("t3_j_pc", b.pc_o, 32'h4000_0400);
    clr(); b.bne_i = 1; b.rs_data_i = 7; b.rt_data_i = 7; step();
    chk("t3_bne_nt", b.pc_o, 32'h4000_0404);
    clr(); b.jr_i = 1; b.jr_target_i = 32'h2000; b.fetch_wait_i = 1; step();
    clr(); b.fetch_wait_i = 1; b.bne_i = 1; b.rs_data_i = 1; b.rt_data_i = 2;
    b.pc_plus4_id_i = 32'h100; b.offset_sl2_i = 32'h40;
    repeat (2) step();
    chk("t4_held", b.pc_o, 32'h4000_0404);
    chk("t4_pending", {31'd0, b.pending_o}, 32'd1);
    b.fetch_wait_i = 0; step();
    chk("t4_jr_pc", b.pc_o, 32'h2000);
    chk("t4_cnt", {16'd0, b.redirect_cnt_o}, 32'd3);
    clr(); b.beq_i = 1; b.rs_data_i = 9; b.rt_data_i = 9;
    b.pc_plus4_id_i = 32'h2004; b.offset_sl2_i = 32'h100; b.id_stall_i = 1;
    step();
    chk("t5_stall_pc", b.pc_o, 32'h2000);
    b.id_stall_i = 0; step();
    chk("t5_taken_pc", b.pc_o, 32'h2104);
    clr(); b.jr_i = 1; b.jr_target_i = 32'h8000; b.fetch_wait_i = 1; step();
    clr(); b.fetch_wait_i = 1; rst = 1; step(); rst = 0;
    chk("t6_rst_pc", b.pc_o, RPC);
    chk("t6_rst_pend", {31'd0, b.pending_o}, 32'd0);
    b.fetch_wait_i = 0; step();
    chk("t6_after_rst", b.pc_o, RPC + 32'd4);
    b.jr_i = 1; b.jr_target_i = 32'h300;
    repeat (65535) step(1'b0);
    chk("t6_cnt_max", {16'd0, b.redirect_cnt_o}, 32'hFFFF);
    step();
    chk("t6_cnt_sat", {16'd0, b.redirect_cnt_o}, 32'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Fetch-side program-counter stage of the 5-stage MIPS pipeline. Sits directly downstream of the offset-shift stage (sign-extended immediate << 2) and consumes its output.
- Owns the PC register and computes PC+4. Resolves beq/bne/j/jal/jr redirects in ID.
- Generates the IF/ID flush.
- Holds a redirect that arrives while instruction fetch is waiting, and applies it once the fetch completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
id_stall_i  input  1  hazard-unit stall: freeze PC, ignore ID redirect this cycle.
fetch_wait_i  input  1  instruction memory not ready: PC must hold.
beq_i  input  1  ID instruction is beq.
bne_i  input  1  ID instruction is bne.
jump_i  input  1  ID instruction is j/jal.
jr_i  input  1  ID instruction is jr.
rs_data_i  input  32  forwarded rs value in ID.
rt_data_i  input  32  forwarded rt value in ID.
offset_sl2_i  input  32  shifted branch offset from the shift stage.
pc_plus4_id_i  input  32  PC+4 of the ID instruction.
jump_index_i  input  26  instr[25:0] of the ID instruction.
jr_target_i  input  32  forwarded rs value for jr.
pc_o  output  32  current fetch PC (registered).
pc_plus4_o  output  32  pc_o + 4, combinational, wraps mod 2^32.
if_id_flush_o  output  1  kill the IF/ID contents at the next edge (combinational).
pending_o  output  1  1 while in state PENDING.
redirect_cnt_o  output  CNT_W  accepted-redirect count, saturating.

Behaviour:
- Reset, synchronous: at the first edge with rst=1, pc_o<=RESET_PC, state<=IDLE, pending target<=0, redirect_cnt_o<=0. if_id_flush_o=0 while rst=1. rst overrides every other input.
- Redirect condition: eq=(rs_data_i==rt_data_i). redir = jr_i | jump_i | (beq_i & eq) | (bne_i & ~eq).
- Target priority: jr > jump > branch.
  - jr: jr_target_i.
  - jump: {pc_plus4_id_i[31:28], jump_index_i, 2'b00}.
  - branch: pc_plus4_id_i + offset_sl2_i, 32-bit with wrap-around and no overflow flag.
- State IDLE, evaluated in priority order:
  - id_stall_i=1: pc holds, no flush, redir ignored.
  - redir & ~fetch_wait_i: pc<=target, flush=1, count++.
  - redir & fetch_wait_i: pc holds, pending target<=target, state<=PENDING, flush=1, count++.
  - fetch_wait_i: pc holds.
  - otherwise: pc<=pc+4.
- State PENDING (pending_o=1):
  - flush=1 every cycle, because the in-flight fetch is wrong-path.
  - id_stall_i and all redirect inputs are ignored.
  - fetch_wait_i=1: pc holds, stay in PENDING.
  - fetch_wait_i=0: pc<=pending target, state<=IDLE.
- Counter: increments by 1 per accepted redirect only. A redirect applied from PENDING is not counted twice. The counter holds at all-ones.
- Latency: a redirect accepted in cycle N is visible on pc_o in cycle N+1, or in the first cycle after fetch_wait_i falls if it was deferred.
- Reset mid-PENDING: pending target is discarded and pc_o=RESET_PC.
- If several of beq_i/bne_i/jump_i/jr_i are asserted together, the priority above applies; the decoder guarantees at most one.
- No combinational path from pc_o to if_id_flush_o. The flush depends only on inputs and state.

Test Plan:
1. Reset, then 3 idle cycles with all controls 0 -> pc_o = 0x0, 0x4, 0x8, 0xC; flush=0; counter=0.
2. beq, rs=rt=5, pc_plus4_id=0x0000_0010, offset_sl2=0xFFFF_FFF0, fetch_wait=0 -> flush=1 that cycle; next pc_o=0x0000_0000; counter=1. Same stimulus with rs=5, rt=6 -> pc_o advances by 4, no flush.
3. j with pc_plus4_id=0x4000_0008, jump_index=0x0000100 -> next pc_o=0x4000_0400. Then bne with rs=rt -> not taken.
4. jr with jr_target=0x0000_2000 while fetch_wait=1 for 3 cycles -> pending_o=1 and flush=1 for 3 cycles, pc_o held; a bne asserted meanwhile is ignored. On the cycle fetch_wait falls, the next pc_o=0x0000_2000 and pending_o returns to 0. Counter increments by exactly 1.
5. Taken beq with id_stall=1 -> pc_o holds, flush=0, counter unchanged. Drop the stall -> the redirect is taken.
6. Reset asserted while in PENDING -> pc_o=RESET_PC, pending_o=0. Force the counter to 0xFFFF with one more redirect -> it stays at 0xFFFF.
